// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue stage that sits in front of the combinational ALU.
// It resolves the A/B operand muxes with EX/MEM and WB forwarding at acceptance
// time, then holds A, B and ALU_Sel in registers. A two-entry skid buffer with
// valid/ready on both sides absorbs a downstream stall without dropping an op.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   flush                    synchronous kill of both entries and of the op offered that cycle
//   in_valid / in_ready      decode-side handshake (in_ready is registered)
//   in_alu_sel, in_a_sel, in_b_sel, in_rs*_addr, in_rs*_data, in_imm, in_pc, in_rd
//                            decoded op and its register-file reads
//   fwd1_* / fwd2_*          EX/MEM (higher priority) and WB forwarding sources
//   out_valid / out_ready    ALU-side handshake
//   out_a, out_b, out_alu_sel, out_rd, out_pc
//                            registered ALU inputs plus carried-along fields
//   stall_cycles             present only when ALU_ISSUE_STALL_CNT_EN is defined:
//                            count of cycles with out_valid && !out_ready
module alu_issue_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_alu_sel,
  input  logic [1:0]        in_a_sel,
  input  logic              in_b_sel,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              fwd1_valid,
  input  logic [REG_AW-1:0] fwd1_rd,
  input  logic [XLEN-1:0]   fwd1_data,
  input  logic              fwd2_valid,
  input  logic [REG_AW-1:0] fwd2_rd,
  input  logic [XLEN-1:0]   fwd2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_a,
  output logic [XLEN-1:0]   out_b,
  output logic [3:0]        out_alu_sel,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_pc
`ifdef ALU_ISSUE_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int unsigned SEL_W = 4;
  localparam int unsigned CNT_W = 32;

  typedef struct packed {
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [SEL_W-1:0]  alu_sel;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   pc;
  } op_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  op_t               main_q, main_d;
  op_t               skid_q, skid_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic [XLEN-1:0]   src1_c, src2_c;
  op_t               new_op_c;
  logic              accept_c, xfer_c;

  // Forwarding: EX/MEM beats WB, register 0 is never forwarded.
  always_comb begin
    src1_c = in_rs1_data;
    if (in_rs1_addr != '0) begin
      if (fwd1_valid && (fwd1_rd == in_rs1_addr))      src1_c = fwd1_data;
      else if (fwd2_valid && (fwd2_rd == in_rs1_addr)) src1_c = fwd2_data;
    end
    src2_c = in_rs2_data;
    if (in_rs2_addr != '0) begin
      if (fwd1_valid && (fwd1_rd == in_rs2_addr))      src2_c = fwd1_data;
      else if (fwd2_valid && (fwd2_rd == in_rs2_addr)) src2_c = fwd2_data;
    end
  end

  // Operand muxes; a_sel 10 and the reserved 11 both select zero.
  always_comb begin
    new_op_c.alu_sel = in_alu_sel;
    new_op_c.rd      = in_rd;
    new_op_c.pc      = in_pc;
    case (in_a_sel)
      2'b00:   new_op_c.a = src1_c;
      2'b01:   new_op_c.a = in_pc;
      default: new_op_c.a = '0;
    endcase
    new_op_c.b = in_b_sel ? in_imm : src2_c;
  end

  assign accept_c = in_valid && in_ready_q;
  assign xfer_c   = out_valid_q && out_ready;

  // Skid-buffer next state; flush wins over every transfer in its cycle.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            main_d  = new_op_c;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept_c && !xfer_c) begin
            skid_d  = new_op_c;
            state_d = ST_SKID;
          end else if (accept_c && xfer_c) begin
            main_d  = new_op_c;
          end else if (xfer_c) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          // in_ready is low here, so no accept can coincide.
          if (xfer_c) begin
            main_d  = skid_q;
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_SKID);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_a       = main_q.a;
  assign out_b       = main_q.b;
  assign out_alu_sel = main_q.alu_sel;
  assign out_rd      = main_q.rd;
  assign out_pc      = main_q.pc;

`ifdef ALU_ISSUE_STALL_CNT_EN
  // Stall counter: only rst_n clears it, flush leaves it alone; wraps naturally.
  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (out_valid_q && !out_ready) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule
